// File: rtl/pss_packet_gate.sv
// Packet gate: forwards or drops framed stream beats on a level cut request,
// with selectable cut policy, framing-error detection and saturating drop statistics.
module pss_packet_gate #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNTW  = 16
) (
   input  logic             rst,
   input  logic             clk,
   input  logic             cut,
   input  logic [1:0]       mode,
   input  logic             clr,
   input  logic [WIDTH-1:0] i_dat,
   input  logic             i_val,
   input  logic             i_sop,
   input  logic             i_eop,
   output logic             i_rdy,
   output logic [WIDTH-1:0] o_dat,
   output logic             o_val,
   output logic             o_sop,
   output logic             o_eop,
   input  logic             o_rdy,
   output logic             lost,
   output logic             err,
   output logic             in_pkt,
   output logic [CNTW-1:0]  drop_words,
   output logic [CNTW-1:0]  drop_pkts
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PKT  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MODE_IMMEDIATE     = 2'd0,
      MODE_BOUNDARY      = 2'd1,
      MODE_TRUNCATE      = 2'd2,
      MODE_IMMEDIATE_ALT = 2'd3
   } mode_t;

   state_t            state_q, state_d;
   logic              lost_q, err_q, in_pkt_q;
   logic [CNTW-1:0]   words_q, words_d;
   logic [CNTW-1:0]   pkts_q, pkts_d;

   logic              fwd;          // beat is forwarded (else consumed and dropped)
   logic              force_eop;    // truncation closes the outbound packet on this beat
   logic              framing_err;  // orphan beat or sop without a preceding eop
   logic              pkt_loss;     // this beat is the first loss of its packet
   logic              accept;
   mode_t             mode_sel;

   assign mode_sel = mode_t'(mode);

   // Per-beat decision: a pure function of state and the inbound beat, never of o_rdy.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      fwd         = 1'b0;
      force_eop   = 1'b0;
      framing_err = 1'b0;
      pkt_loss    = 1'b0;
      state_d     = state_q;
      if (i_sop) begin
         framing_err = (state_q != ST_IDLE);
         if (cut) begin
            pkt_loss = 1'b1;
            state_d  = i_eop ? ST_IDLE : ST_DROP;
         end else begin
            fwd     = 1'b1;
            state_d = i_eop ? ST_IDLE : ST_PKT;
         end
      end else begin
         case (state_q)
            ST_PKT: begin
               if (!cut || mode_sel == MODE_BOUNDARY) begin
                  fwd     = 1'b1;
                  state_d = i_eop ? ST_IDLE : ST_PKT;
               end else if (mode_sel == MODE_TRUNCATE) begin
                  fwd       = 1'b1;
                  force_eop = 1'b1;
                  pkt_loss  = ~i_eop;
                  state_d   = i_eop ? ST_IDLE : ST_DROP;
               end else begin
                  pkt_loss = 1'b1;
                  state_d  = i_eop ? ST_IDLE : ST_DROP;
               end
            end
            ST_DROP: begin
               state_d = i_eop ? ST_IDLE : ST_DROP;
            end
            default: begin
               framing_err = 1'b1;
               state_d     = ST_IDLE;
            end
         endcase
      end
   end

   assign i_rdy  = fwd ? o_rdy : 1'b1;
   assign o_val  = i_val & fwd;
   assign o_dat  = i_dat;
   assign o_sop  = i_sop;
   assign o_eop  = i_eop | force_eop;
   assign accept = i_val & i_rdy;

   // Statistics: clear wins over a same-cycle increment; both counters stick at all-ones.
   always_comb begin
      words_d = words_q;
      pkts_d  = pkts_q;
      if (clr) begin
         words_d = '0;
         pkts_d  = '0;
      end else begin
         if (accept && !fwd && words_q != '1) begin
            words_d = words_q + 1'b1;
         end
         if (accept && pkt_loss && pkts_q != '1) begin
            pkts_d = pkts_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         lost_q   <= 1'b0;
         err_q    <= 1'b0;
         in_pkt_q <= 1'b0;
         words_q  <= '0;
         pkts_q   <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         if (accept) begin
            state_q  <= state_d;
            in_pkt_q <= (state_d != ST_IDLE);
         end
         lost_q  <= accept & ~fwd;
         err_q   <= accept & framing_err;
         words_q <= words_d;
         pkts_q  <= pkts_d;
      end
   end

   assign lost       = lost_q;
   assign err        = err_q;
   assign in_pkt     = in_pkt_q;
   assign drop_words = words_q;
   assign drop_pkts  = pkts_q;

endmodule

// File: tb/tb_pss_packet_gate.sv
// Self-checking bench for pss_packet_gate: directed cut-policy scenarios plus random
// traffic, checked against a packet-level reference model kept in the bench.
module tb_pss_packet_gate;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cut = 1'b0;
   logic [1:0]   mode = 2'd0;
   logic         clr = 1'b0;
   logic [W-1:0] i_dat = '0;
   logic         i_val = 1'b0;
   logic         i_sop = 1'b0;
   logic         i_eop = 1'b0;
   logic         o_rdy = 1'b0;

   logic         i_rdy, o_val, o_sop, o_eop, lost, err, in_pkt;
   logic [W-1:0] o_dat;
   logic [15:0]  drop_words, drop_pkts;

   logic         s_i_rdy, s_o_val, s_o_sop, s_o_eop, s_lost, s_err, s_in_pkt;
   logic [W-1:0] s_o_dat;
   logic [1:0]   s_drop_words, s_drop_pkts;

   pss_packet_gate #(.WIDTH(W), .CNTW(16)) dut (
      .rst(rst), .clk(clk), .cut(cut), .mode(mode), .clr(clr),
      .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_rdy(i_rdy),
      .o_dat(o_dat), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_rdy(o_rdy),
      .lost(lost), .err(err), .in_pkt(in_pkt),
      .drop_words(drop_words), .drop_pkts(drop_pkts)
   );

   pss_packet_gate #(.WIDTH(W), .CNTW(2)) dut_sat (
      .rst(rst), .clk(clk), .cut(cut), .mode(mode), .clr(clr),
      .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_rdy(s_i_rdy),
      .o_dat(s_o_dat), .o_val(s_o_val), .o_sop(s_o_sop), .o_eop(s_o_eop), .o_rdy(o_rdy),
      .lost(s_lost), .err(s_err), .in_pkt(s_in_pkt),
      .drop_words(s_drop_words), .drop_pkts(s_drop_pkts)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: packet open / packet kept, plus ideal saturating counters.
   bit m_open = 1'b0;
   bit m_keep = 1'b0;
   int m_dw = 0, m_dp = 0;
   int s_dw = 0, s_dp = 0;

   int lost_hi = 0;
   int err_hi  = 0;
   bit rdy_random = 1'b0;
   logic [W+1:0] out_q[$];

   task automatic model_clear();
      m_dw = 0; m_dp = 0; s_dw = 0; s_dp = 0;
   endtask

   task automatic check_regs(input string tag, input bit e_lost, input bit e_err);
      n_cmp++;
      if ({lost, err, s_lost, s_err} !== {e_lost, e_err, e_lost, e_err}) begin
         n_bad++;
         $display("FAIL %s pulses: lost/err=%b%b sat=%b%b required %b%b", tag, lost, err, s_lost, s_err, e_lost, e_err);
      end
      n_cmp++;
      if ({in_pkt, s_in_pkt} !== {m_open, m_open}) begin
         n_bad++;
         $display("FAIL %s in_pkt: got %b/%b required %b", tag, in_pkt, s_in_pkt, m_open);
      end
      n_cmp++;
      if (drop_words !== 16'(m_dw) || drop_pkts !== 16'(m_dp) ||
          s_drop_words !== 2'(s_dw) || s_drop_pkts !== 2'(s_dp)) begin
         n_bad++;
         $display("FAIL %s counters: words/pkts=%0d/%0d sat=%0d/%0d required %0d/%0d sat=%0d/%0d",
                  tag, drop_words, drop_pkts, s_drop_words, s_drop_pkts, m_dw, m_dp, s_dw, s_dp);
      end
      lost_hi += int'(lost);
      err_hi  += int'(err);
   endtask

   task automatic idle(input int n);
      i_val = 1'b0;
      for (int k = 0; k < n; k++) begin
         i_sop = 1'($urandom);
         i_eop = 1'($urandom);
         @(posedge clk); #1;
         if (clr) model_clear();
         check_regs("idle", 1'b0, 1'b0);
      end
      i_sop = 1'b0;
      i_eop = 1'b0;
   endtask

   // Present one beat and hold it until accepted; every cycle is checked.
   task automatic do_beat(input logic [W-1:0] dat, input bit sop, input bit eop);
      bit e_fwd, e_feop, e_err, e_pkt, e_open, e_keep, acc, e_rdy, done;
      e_fwd = 0; e_feop = 0; e_err = 0; e_pkt = 0; e_open = m_open; e_keep = m_keep;
      if (sop) begin
         e_err = m_open; e_fwd = !cut; e_pkt = cut; e_open = !eop; e_keep = !cut;
      end else if (!m_open) begin
         e_err = 1; e_open = 0; e_keep = 0;
      end else if (!m_keep) begin
         e_open = !eop;
      end else if (!cut || mode == 2'd1) begin
         e_fwd = 1; e_open = !eop; e_keep = 1;
      end else if (mode == 2'd2) begin
         e_fwd = 1; e_feop = 1; e_pkt = !eop; e_open = !eop; e_keep = 0;
      end else begin
         e_pkt = 1; e_open = !eop; e_keep = 0;
      end

      i_dat = dat; i_sop = sop; i_eop = eop; i_val = 1'b1;
      done = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         o_rdy = rdy_random ? ($urandom_range(3) != 0) : 1'b1;
         @(negedge clk);
         e_rdy = e_fwd ? o_rdy : 1'b1;
         acc   = e_rdy;
         n_cmp++;
         if ({o_val, i_rdy, s_o_val, s_i_rdy} !== {e_fwd, e_rdy, e_fwd, e_rdy}) begin
            n_bad++;
            $display("FAIL decision: o_val/i_rdy=%b%b sat=%b%b required %b%b", o_val, i_rdy, s_o_val, s_i_rdy, e_fwd, e_rdy);
         end
         if (acc && e_fwd) begin
            n_cmp++;
            if ({o_dat, o_sop, o_eop} !== {dat, sop, eop | e_feop} ||
                {s_o_dat, s_o_sop, s_o_eop} !== {dat, sop, eop | e_feop}) begin
               n_bad++;
               $display("FAIL out beat: dat/sop/eop=%h/%b/%b required %h/%b/%b", o_dat, o_sop, o_eop, dat, sop, eop | e_feop);
            end
            out_q.push_back({o_dat, o_sop, o_eop});
         end
         @(posedge clk); #1;
         if (clr) begin
            model_clear();
         end else if (acc) begin
            if (!e_fwd) begin
               if (m_dw < 65535) m_dw++;
               if (s_dw < 3) s_dw++;
            end
            if (e_pkt) begin
               if (m_dp < 65535) m_dp++;
               if (s_dp < 3) s_dp++;
            end
         end
         if (acc) begin
            m_open = e_open;
            m_keep = e_keep;
            done   = 1;
         end
         check_regs("beat", acc & !e_fwd, acc & e_err);
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL beat timeout: not accepted within 64 cycles");
      end
      i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      m_open = 0; m_keep = 0;
      model_clear();
      n_cmp++;
      if ({lost, err, in_pkt, drop_words, drop_pkts} !== '0) begin
         n_bad++;
         $display("FAIL reset state: lost/err/in_pkt=%b%b%b words=%0d pkts=%0d required all 0",
                  lost, err, in_pkt, drop_words, drop_pkts);
      end
      rst = 1'b0;
   endtask

   task automatic clear_counters();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      model_clear();
      check_regs("clear", 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      // A non-sop beat during reset is judged as in IDLE: dropped, ready high.
      i_val = 1'b1; i_sop = 1'b0; o_rdy = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_val, i_rdy} !== 2'b01) begin
         n_bad++;
         $display("FAIL reset decision: o_val/i_rdy=%b%b required 01", o_val, i_rdy);
      end
      i_val = 1'b0;
      apply_reset();
      idle(2);
   endtask

   task automatic test_pass_through();
      logic [W+1:0] sent[$];
      logic [W-1:0] d;
      cut = 1'b0; rdy_random = 1'b1; out_q.delete(); lost_hi = 0;
      for (int p = 0; p < 3; p++) begin
         for (int b = 0; b < 4; b++) begin
            mode = 2'($urandom);
            d = W'($urandom);
            sent.push_back({d, b == 0, b == 3});
            do_beat(d, b == 0, b == 3);
            idle($urandom_range(2));
         end
      end
      n_cmp++;
      if (out_q.size() != 12 || out_q != sent) begin
         n_bad++;
         $display("FAIL pass_through stream: %0d beats out, required 12 intact", out_q.size());
      end
      n_cmp++;
      if (drop_words !== 16'd0 || drop_pkts !== 16'd0 || lost_hi != 0) begin
         n_bad++;
         $display("FAIL pass_through stats: words=%0d pkts=%0d lost_cycles=%0d required 0/0/0", drop_words, drop_pkts, lost_hi);
      end
   endtask

   task automatic test_cut_mid(input logic [1:0] m, input int e_out, input int e_dw);
      clear_counters();
      mode = m; rdy_random = 1'b0; out_q.delete(); lost_hi = 0;
      for (int b = 0; b < 5; b++) begin
         cut = (b >= 2);
         do_beat(W'(8'h40 + b), b == 0, b == 4);
      end
      cut = 1'b0;
      idle(1);
      n_cmp++;
      if (out_q.size() != e_out || drop_words !== 16'(e_dw) || drop_pkts !== 16'd1 || lost_hi != e_dw) begin
         n_bad++;
         $display("FAIL cut_mode%0d: out=%0d words=%0d pkts=%0d lost_cycles=%0d required %0d/%0d/1/%0d",
                  m, out_q.size(), drop_words, drop_pkts, lost_hi, e_out, e_dw, e_dw);
      end
      for (int k = 0; k < out_q.size(); k++) begin
         n_cmp++;
         if (out_q[k][0] !== (k == e_out - 1 && m == 2'd2)) begin
            n_bad++;
            $display("FAIL cut_mode%0d eop beat %0d: got %b", m, k, out_q[k][0]);
         end
      end
   endtask

   task automatic test_boundary();
      clear_counters();
      mode = 2'd1; rdy_random = 1'b1; out_q.delete();
      for (int b = 0; b < 4; b++) begin
         cut = (b >= 2);
         do_beat(W'($urandom), b == 0, b == 3);
      end
      for (int p = 0; p < 2; p++) begin
         for (int b = 0; b < 3; b++) do_beat(W'($urandom), b == 0, b == 2);
      end
      cut = 1'b0;
      n_cmp++;
      if (out_q.size() != 4 || out_q[out_q.size()-1][0] !== 1'b1 || drop_pkts !== 16'd2 || drop_words !== 16'd6) begin
         n_bad++;
         $display("FAIL boundary: out=%0d pkts=%0d words=%0d required 4/2/6", out_q.size(), drop_pkts, drop_words);
      end
   endtask

   task automatic test_orphan_resync();
      cut = 1'b0; mode = 2'd0; rdy_random = 1'b0;
      do_beat(8'h11, 1, 0);
      apply_reset();
      err_hi = 0;
      do_beat(8'h12, 0, 0);
      do_beat(8'h13, 1, 0);
      do_beat(8'h14, 1, 0);
      do_beat(8'h15, 0, 1);
      idle(1);
      n_cmp++;
      if (err_hi != 2 || drop_words !== 16'd1 || drop_pkts !== 16'd0) begin
         n_bad++;
         $display("FAIL orphan_resync: err_cycles=%0d words=%0d pkts=%0d required 2/1/0", err_hi, drop_words, drop_pkts);
      end
   endtask

   task automatic test_saturation();
      clear_counters();
      cut = 1'b1; mode = 2'($urandom); rdy_random = 1'b0;
      for (int b = 0; b < 5; b++) do_beat(W'($urandom), 1, 1);
      idle(2);
      n_cmp++;
      if (s_drop_words !== 2'd3 || s_drop_pkts !== 2'd3 || drop_words !== 16'd5) begin
         n_bad++;
         $display("FAIL saturation: sat words/pkts=%0d/%0d wide words=%0d required 3/3/5", s_drop_words, s_drop_pkts, drop_words);
      end
      clr = 1'b1;
      do_beat(W'($urandom), 1, 1);
      clr = 1'b0;
      n_cmp++;
      if (s_drop_words !== 2'd0 || s_drop_pkts !== 2'd0 || drop_words !== 16'd0) begin
         n_bad++;
         $display("FAIL clear_priority: sat words/pkts=%0d/%0d wide words=%0d required 0/0/0", s_drop_words, s_drop_pkts, drop_words);
      end
      cut = 1'b0;
   endtask

   task automatic test_random();
      rdy_random = 1'b1;
      for (int n = 0; n < 300; n++) begin
         cut  = ($urandom_range(3) == 0);
         mode = 2'($urandom);
         clr  = ($urandom_range(19) == 0);
         do_beat(W'($urandom), $urandom_range(3) == 0, $urandom_range(2) == 0);
         clr = 1'b0;
         if ($urandom_range(4) == 0) idle($urandom_range(1, 2));
      end
      cut = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_cut_mid(2'd0, 2, 3);
      test_cut_mid(2'd2, 3, 2);
      test_boundary();
      test_orphan_resync();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
